// File: rtl/linear_feedback_shift_register_updown.sv
// rtl/linear_feedback_shift_register_updown.sv - reversible maximal-length Fibonacci LFSR counter
//
// Purpose: pseudo-random up/down sequence source. An up step advances the LFSR
// and a down step applies the exact inverse, so the sequence can be retraced.
// overflow flags each pass through the SEED state.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset (count=SEED, overflow=0)
//   enable    in   1      1 = step on this edge, 0 = hold
//   up_down   in   1      1 = forward step, 0 = inverse step
//   count     out  WIDTH  current LFSR state (registered)
//   overflow  out  1      wrap indication (registered)
//
// Configuration macros:
//   WIDTH                    register width (3..32), 8 when undefined
//   LFSR_OVERFLOW_STICKY_EN  overflow latches high until reset when defined
`ifndef WIDTH
`define WIDTH 8
`endif
module linear_feedback_shift_register_updown #(
  parameter int WIDTH = `WIDTH,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  // Maximal-length tap set (XAPP052). The top bit is always a tap; b/c/d
  // list the remaining 1-based tap positions, 0 meaning unused.
  function automatic logic [WIDTH-1:0] tap_mask();
    int b, c, d;
    logic [WIDTH-1:0] m;
    b = 0; c = 0; d = 0;
    case (WIDTH)
      3:  b = 2;
      4:  b = 3;
      5:  b = 3;
      6:  b = 5;
      7:  b = 6;
      8:  begin b = 6;  c = 5;  d = 4; end
      9:  b = 5;
      10: b = 7;
      11: b = 9;
      12: begin b = 6;  c = 4;  d = 1; end
      13: begin b = 4;  c = 3;  d = 1; end
      14: begin b = 5;  c = 3;  d = 1; end
      15: b = 14;
      16: begin b = 15; c = 13; d = 4; end
      17: b = 14;
      18: b = 11;
      19: begin b = 6;  c = 2;  d = 1; end
      20: b = 17;
      21: b = 19;
      22: b = 21;
      23: b = 18;
      24: begin b = 23; c = 22; d = 17; end
      25: b = 22;
      26: begin b = 6;  c = 2;  d = 1; end
      27: begin b = 5;  c = 2;  d = 1; end
      28: b = 25;
      29: b = 27;
      30: begin b = 6;  c = 4;  d = 1; end
      31: b = 28;
      32: begin b = 22; c = 2;  d = 1; end
      default: ;
    endcase
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i + 1 == WIDTH) || (i + 1 == b) || (i + 1 == c) || (i + 1 == d)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAPS    = tap_mask();
  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_BIT = {{(WIDTH-1){1'b0}}, 1'b1};
  // Inverse step: the bit shifted out at the top is recovered from the
  // feedback bit (now at bit 0) XOR the other taps, each now one bit higher.
  localparam logic [WIDTH-1:0] TAPS_INV = ((TAPS & ~MSB_BIT) << 1) | LSB_BIT;

  logic             fb;
  logic             fb_inv;
  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] next_dn;
  logic [WIDTH-1:0] next_count;
  logic             wrap;

  always_comb begin
    fb      = ^(count & TAPS);
    fb_inv  = ^(count & TAPS_INV);
    next_up = {count[WIDTH-2:0], fb};
    next_dn = {fb_inv, count[WIDTH-1:1]};
  end

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    if (enable) begin
      if (count == '0) begin
        // Lock-up recovery: all-zero would otherwise be a fixed point.
        next_count = SEED;
      end else if (up_down) begin
        next_count = next_up;
        wrap       = (next_up == SEED);
      end else begin
        next_count = next_dn;
        wrap       = (count == SEED);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= SEED;
      overflow <= 1'b0;
    end else begin
      count <= next_count;
`ifdef LFSR_OVERFLOW_STICKY_EN
      overflow <= overflow | wrap;
`else
      overflow <= wrap;
`endif
    end
  end

endmodule

// File: tb/tb_linear_feedback_shift_register_updown.sv
// tb/tb_linear_feedback_shift_register_updown.sv - self-checking bench for the up/down LFSR
module tb_linear_feedback_shift_register_updown;

`ifdef LFSR_OVERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic [7:0] count;
  logic       overflow;

  linear_feedback_shift_register_updown dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up_down  (up_down),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the full 255-entry sequence plus a position in it. Up moves the
  // position forward, down moves it back; the seed sits at position 0.
  logic [7:0] seq [255];
  int         pos;
  bit         m_ov;
  bit         check_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit w;
    if (reset) begin
      pos  = 0;
      m_ov = 1'b0;
    end else if (enable) begin
      if (up_down) begin
        pos = (pos + 1) % 255;
        w   = (pos == 0);
      end else begin
        w   = (pos == 0);
        pos = (pos + 254) % 255;
      end
      m_ov = STICKY ? (m_ov | w) : w;
    end else begin
      m_ov = STICKY ? m_ov : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic ud);
    enable  = en;
    up_down = ud;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] s;
    bit         seen [256];
    int         distinct;
    int         pulses;

    reset   = 1'b1;
    enable  = 1'b0;
    up_down = 1'b1;

    // Build the forward sequence from the polynomial x^8+x^6+x^5+x^4+1.
    s = 8'h01;
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      if (!seen[s]) distinct++;
      seen[s] = 1'b1;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    chk("model_seq1", seq[1], 8'h02);
    chk("model_seq4", seq[4], 8'h11);
    chk("model_seq6", seq[6], 8'h47);
    chk("model_seq254", seq[254], 8'h80);
    chk("model_period", s, 8'h01);
    chk("model_distinct", distinct, 255);

    fork
      forever begin
        @(negedge clk);
        if (check_en) begin
          chk("cyc_count", count, seq[pos]);
          chk("cyc_overflow", overflow, m_ov);
          chk("cyc_nonzero", count != 8'h00, 1'b1);
        end
      end
    join_none

    // Reset is visible before any clock edge.
    #1;
    chk("reset_count", count, 8'h01);
    chk("reset_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    check_en = 1'b1;

    // Hold with enable low.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("hold_count", count, 8'h01);
    chk("hold_overflow", overflow, 1'b0);

    // Forward stepping and the full period.
    step(1'b1, 1'b1); chk("up1", count, 8'h02);
    step(1'b1, 1'b1); chk("up2", count, 8'h04);
    step(1'b1, 1'b1); chk("up3", count, 8'h08);
    step(1'b1, 1'b1); chk("up4", count, 8'h11);
    step(1'b1, 1'b1); chk("up5", count, 8'h23);
    step(1'b1, 1'b1); chk("up6", count, 8'h47);
    pulses = 0;
    for (int i = 6; i < 255; i++) begin
      step(1'b1, 1'b1);
      if (overflow) pulses++;
    end
    chk("period_count", count, 8'h01);
    chk("period_overflow", overflow, 1'b1);
    chk("period_pulses", pulses, 1);
    step(1'b0, 1'b1);
    chk("post_wrap_hold_ov", overflow, STICKY ? 1'b1 : 1'b0);

    // Reverse stepping around the seed.
    step(1'b1, 1'b1); chk("rev_up_count", count, 8'h02);
    chk("rev_up_ov", overflow, STICKY ? 1'b1 : 1'b0);
    step(1'b1, 1'b0); chk("dn1_count", count, 8'h01);
    chk("dn1_ov", overflow, STICKY ? 1'b1 : 1'b0);
    step(1'b1, 1'b0); chk("dn2_count", count, 8'h80);
    chk("dn2_ov", overflow, 1'b1);
    step(1'b1, 1'b1); chk("up80_count", count, 8'h01);
    chk("up80_ov", overflow, 1'b1);

    // Random direction, always enabled, then random enable as well.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Make sure the mid-stream reset starts from a state other than the seed.
    if (count == 8'h01) step(1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", count, 8'h01);
    chk("async_reset_ov", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1);
    chk("resume_count", count, 8'h02);
    chk("resume_ov", overflow, 1'b0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
